// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous-SRAM controller.
//   state_t : controller phases IDLE / SETUP / STROBE / HOLD
//   chan_t  : requesting channel, instruction fetch or data
//   STROBE_ON / STROBE_OFF : levels of the active-low SRAM strobes
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef enum logic {
        CH_FETCH = 1'b0,
        CH_DATA  = 1'b1
    } chan_t;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Two-request arbiter for the SRAM controller.
// Build option: SRAM_CTRL_RR_EN selects round-robin on a tie (the channel
// not served last wins, pointer moves in HOLD); otherwise fixed priority,
// data over fetch.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   req_fetch_i    fetch channel request
//   req_data_i     data channel request
//   state_i        controller state; a grant is accepted in IDLE
//   grant_o        combinational choice, meaningful while state_i is IDLE
//   owner_o        channel that owns the transaction in flight
module sram_arbiter
    import sram_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   req_fetch_i,
    input  logic   req_data_i,
    input  state_t state_i,
    output chan_t  grant_o,
    output chan_t  owner_o
);

    chan_t owner_q, owner_d;

`ifdef SRAM_CTRL_RR_EN
    // Pointer names the channel that wins the next tie.
    chan_t ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= CH_DATA;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_i == HOLD) begin
            ptr_d = (owner_q == CH_DATA) ? CH_FETCH : CH_DATA;
        end
    end

    always_comb begin
        if (req_data_i && req_fetch_i) begin
            grant_o = ptr_q;
        end else if (req_data_i) begin
            grant_o = CH_DATA;
        end else begin
            grant_o = CH_FETCH;
        end
    end
`else
    always_comb begin
        grant_o = req_data_i ? CH_DATA : CH_FETCH;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q <= CH_DATA;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        if (state_i == IDLE && (req_fetch_i || req_data_i)) begin
            owner_d = grant_o;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/sram_ctrl.sv
// Two-channel synchronous controller for an asynchronous 16-bit SRAM.
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES+1 cycles) -> HOLD,
// with ready pulsing in HOLD and one IDLE cycle between accesses.
// Build option: SRAM_CTRL_RR_EN (handled inside sram_arbiter) selects
// round-robin arbitration instead of data-over-fetch priority.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   ifReq/ifAddr                  fetch read request
//   ifReady/ifData                fetch completion pulse and held read word
//   dReq/dWe/dAddr/dWData         data request (read or write)
//   dReady/dRData                 data completion pulse and held read word
//   sramAddr/sramData             SRAM address and bidirectional data pins
//   sramCe_n/sramOe_n/sramWe_n    active-low SRAM strobes
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifReady,
    output logic [DATA_W-1:0] ifData,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWData,
    output logic              dReady,
    output logic [DATA_W-1:0] dRData,
    output logic [ADDR_W-1:0] sramAddr,
    inout  wire  [DATA_W-1:0] sramData,
    output logic              sramCe_n,
    output logic              sramOe_n,
    output logic              sramWe_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    chan_t             grant;
    chan_t             owner;
    logic              bus_drive;

    sram_arbiter u_arb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .req_fetch_i (ifReq),
        .req_data_i  (dReq),
        .state_i     (state_q),
        .grant_o     (grant),
        .owner_o     (owner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            if_data_q <= '0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            if_data_q <= if_data_d;
            d_data_q  <= d_data_d;
        end
    end

    // Next state and datapath latching
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        if_data_d = if_data_q;
        d_data_d  = d_data_q;
        case (state_q)
            IDLE: begin
                if (ifReq || dReq) begin
                    state_d = SETUP;
                    if (grant == CH_DATA) begin
                        addr_d  = dAddr;
                        we_d    = dWe;
                        wdata_d = dWData;
                    end else begin
                        addr_d = ifAddr;
                        we_d   = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                wait_d  = '0;
            end
            STROBE: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = HOLD;
                    // Read data is taken while OE is still asserted.
                    if (!we_q) begin
                        if (owner == CH_DATA) begin
                            d_data_d = sramData;
                        end else begin
                            if_data_d = sramData;
                        end
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        sramCe_n  = STROBE_OFF;
        sramOe_n  = STROBE_OFF;
        sramWe_n  = STROBE_OFF;
        bus_drive = 1'b0;
        ifReady   = 1'b0;
        dReady    = 1'b0;
        case (state_q)
            SETUP: begin
                sramCe_n  = STROBE_ON;
                bus_drive = we_q;
            end
            STROBE: begin
                sramCe_n  = STROBE_ON;
                bus_drive = we_q;
                if (we_q) begin
                    sramWe_n = STROBE_ON;
                end else begin
                    sramOe_n = STROBE_ON;
                end
            end
            HOLD: begin
                sramCe_n  = STROBE_ON;
                bus_drive = we_q;
                if (owner == CH_DATA) begin
                    dReady = 1'b1;
                end else begin
                    ifReady = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign sramAddr = addr_q;
    assign sramData = bus_drive ? wdata_q : 'z;
    assign ifData   = if_data_q;
    assign dRData   = d_data_q;

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Two-channel synchronous controller for the board's asynchronous 16-bit SRAM. It replaces the old combinational memory glue with a clocked FSM that generates properly timed address, chip-enable, output-enable and write-enable sequences with a configurable number of wait states. It arbitrates between an instruction-fetch channel and a data channel, and returns results over a req/ready handshake. It sits between the CPU pipeline (fetch and MEM stages) and the SRAM pins.

## Interface
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 1, extra strobe cycles beyond the minimum of one (0..15)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- ifReq  in  1  fetch channel read request
- ifAddr  in  ADDR_W  fetch address
- ifReady  out  1  one-cycle pulse; ifData valid
- ifData  out  DATA_W  fetched word, held until next fetch completes
- dReq  in  1  data channel request
- dWe  in  1  1 = write, 0 = read
- dAddr  in  ADDR_W  data address
- dWData  in  DATA_W  write data
- dReady  out  1  one-cycle pulse; access complete, dRData valid for reads
- dRData  out  DATA_W  read word, held until next data read completes
- sramAddr  out  ADDR_W  SRAM address pins
- sramData  inout  DATA_W  SRAM data pins; Z unless writing
- sramCe_n, sramOe_n, sramWe_n  out  1 each  active-low strobes

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: all strobes high, bus Z. On any req, the arbiter picks a channel. Address, direction and write data are latched into internal registers, and the FSM moves to SETUP.
- SETUP (1 cycle): sramAddr driven, sramCe_n=0, Oe_n/We_n high. On a write, sramData is driven from the latched data.
- STROBE (WAIT_CYCLES+1 cycles, wait counter): read asserts sramOe_n=0; write asserts sramWe_n=0. On a read, sramData is sampled into the channel's read register on the last STROBE cycle.
- HOLD (1 cycle): strobes high, sramCe_n=0, address and write data still driven. The winning channel's ready pulses. Next state is IDLE.
- The fetch channel is always a read.
- Requester holds req, addr and data stable until ready. A req dropped early is not aborted; the transaction completes and ready still pulses.
- Ready and bus drive are never active for both channels simultaneously.

## Timing
- Req high in IDLE at cycle 0 gives SETUP at 1, STROBE at 2..2+W, HOLD with ready at 3+W, and IDLE at 4+W. Latency is WAIT_CYCLES+3 cycles from request to ready.
- One mandatory IDLE cycle between transactions, giving a throughput of one access per WAIT_CYCLES+4 cycles.
- A req still high in the IDLE cycle after ready starts a new transaction. The requester deasserts req in the ready cycle unless it wants another access.
- Reset values: sramCe_n=sramOe_n=sramWe_n=1, sramData=Z, sramAddr=0, ifReady=dReady=0, ifData=dRData=0, state IDLE, wait counter 0, arbiter pointer at data channel.
- Reset asserted mid-transaction: on the next edge the FSM returns to IDLE with all strobes high and bus Z. No ready pulse is issued and read registers are cleared.
- Simultaneous ifReq and dReq are resolved per Configuration.

## Configuration
- SRAM_CTRL_RR_EN defined: round-robin arbitration. The channel not served last wins a tie, and the pointer updates in HOLD.
- SRAM_CTRL_RR_EN undefined: fixed priority, data over fetch. The fetch channel may starve under continuous data traffic.

## Structure
- Package sram_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - the channel-select enum (CH_FETCH, CH_DATA);
  - the STROBE_ON=1'b0 / STROBE_OFF=1'b1 constants.
- Sub-module sram_arbiter (2-request arbiter, grant valid in IDLE, pointer update on an accept strobe) contains the SRAM_CTRL_RR_EN ifdef. The rest of sram_ctrl is macro-free.

## Test plan
- Data write dAddr=0x00012, dWData=0xBEEF, WAIT_CYCLES=1 -> sramWe_n low exactly cycles 2–3, sramData=0xBEEF cycles 1–4, dReady pulse at cycle 4.
- Read back 0x00012 on fetch channel -> sramOe_n low cycles 2–3, ifData=0xBEEF with ifReady at cycle 4, sramData Z throughout.
- ifReq and dReq both held high for 4 transactions -> without macro, 4 data grants; with SRAM_CTRL_RR_EN, grants alternate D,F,D,F.
- rst low during STROBE of a write -> next cycle all strobes 1, bus Z, no dReady, and a subsequent read returns normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 -> dReady at cycle 3 and 6 respectively; back-to-back requests separated by exactly one IDLE cycle.
